mem_port_arbiter: RTL and testbench

- Shares one memory port between the instruction-fetch requester and the load/store requester of the multi-cycle RISC-V core.
- Allows exactly one transaction in flight at a time; round-robin on simultaneous requests.
- Sits between the core's fetch/load-store FSM and the single memory-side valid/ready request + response channel pair; routes read data back to the owning requester.
- Counts arbitration conflicts for a performance-counter slot.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side channels around the shared memory port.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   i_addr;
    logic                i_valid;
    logic                i_ready;
    logic [DATA_W-1:0]   i_rdata;
    logic                i_rvalid;
    logic                i_rready;

    logic [ADDR_W-1:0]   d_addr;
    logic                d_read;
    logic                d_write;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_wstrb;
    logic                d_ready;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_rvalid;
    logic                d_rready;

    logic [ADDR_W-1:0]   m_addr;
    logic                m_read;
    logic                m_write;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_req_ready;
    logic [DATA_W-1:0]   m_rdata;
    logic                m_rvalid;
    logic                m_rready;

    modport master (
        output i_addr, i_valid, i_rready,
        output d_addr, d_read, d_write, d_wdata, d_wstrb, d_rready,
        output m_req_ready, m_rdata, m_rvalid,
        input  i_ready, i_rdata, i_rvalid,
        input  d_ready, d_rdata, d_rvalid,
        input  m_addr, m_read, m_write, m_wdata, m_wstrb, m_rready
    );

    modport slave (
        input  i_addr, i_valid, i_rready,
        input  d_addr, d_read, d_write, d_wdata, d_wstrb, d_rready,
        input  m_req_ready, m_rdata, m_rvalid,
        output i_ready, i_rdata, i_rvalid,
        output d_ready, d_rdata, d_rvalid,
        output m_addr, m_read, m_write, m_wdata, m_wstrb, m_rready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction
// in flight, round-robin on ties, with a counter of tie cycles seen in IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic [31:0]          conflict_cnt,
    output logic [1:0]           dbg_state
);
    localparam int STRB_W = DATA_W / 8;

    // Handshakes: a request or response transfers in a cycle where valid and ready
    // are both high at the rising edge; ready may depend combinationally on valid.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {INST = 1'b0, DATA = 1'b1} side_t;

    state_t state, next_state;
    side_t  owner, last_grant, winner;
    logic   grant, tie;
    logic   rready_sel;
    logic   i_pend, d_pend;

    assign i_pend    = bus.i_valid;
    assign d_pend    = bus.d_read | bus.d_write;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= INST;
            last_grant   <= DATA;
            conflict_cnt <= 32'd0;
        end else begin
            state <= next_state;
            if (grant) begin
                owner      <= winner;
                last_grant <= winner;
            end
            if (tie) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    always_comb begin
        next_state   = state;
        grant        = 1'b0;
        tie          = 1'b0;
        winner       = INST;
        rready_sel   = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_rdata  = {DATA_W{1'b0}};
        bus.i_rvalid = 1'b0;
        bus.d_ready  = 1'b0;
        bus.d_rdata  = {DATA_W{1'b0}};
        bus.d_rvalid = 1'b0;
        bus.m_addr   = {ADDR_W{1'b0}};
        bus.m_read   = 1'b0;
        bus.m_write  = 1'b0;
        bus.m_wdata  = {DATA_W{1'b0}};
        bus.m_wstrb  = {STRB_W{1'b0}};
        bus.m_rready = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_pend && d_pend) begin
                    grant  = 1'b1;
                    tie    = 1'b1;
                    winner = (last_grant == INST) ? DATA : INST;
                end else if (i_pend) begin
                    grant  = 1'b1;
                    winner = INST;
                end else if (d_pend) begin
                    grant  = 1'b1;
                    winner = DATA;
                end
                if (grant) next_state = REQ;
            end
            REQ: begin
                if (owner == INST) begin
                    bus.m_addr  = bus.i_addr;
                    bus.m_read  = 1'b1;
                    bus.i_ready = bus.m_req_ready;
                    if (bus.m_req_ready) next_state = RESP;
                end else begin
                    // A store takes priority if the core raises both read and write.
                    bus.m_addr  = bus.d_addr;
                    bus.m_write = bus.d_write;
                    bus.m_read  = bus.d_read & ~bus.d_write;
                    bus.m_wdata = bus.d_wdata;
                    bus.m_wstrb = bus.d_wstrb;
                    bus.d_ready = bus.m_req_ready;
                    if (bus.m_req_ready) next_state = bus.d_write ? IDLE : RESP;
                end
            end
            RESP: begin
                if (owner == INST) begin
                    bus.i_rdata  = bus.m_rdata;
                    bus.i_rvalid = bus.m_rvalid;
                    rready_sel   = bus.i_rready;
                end else begin
                    bus.d_rdata  = bus.m_rdata;
                    bus.d_rvalid = bus.m_rvalid;
                    rready_sel   = bus.d_rready;
                end
                bus.m_rready = rready_sel;
                if (bus.m_rvalid && rready_sel) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected memory requests and
// read responses into a queue, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int W  = 5 + AW + DW + SW;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] conflict_cnt;
  logic [1:0]  dbg_state;
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    errors = errors + 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- record encoders ----------------
  function automatic logic [W-1:0] req_rec(input logic wr, input logic rd, input logic ir,
                                           input logic dr, input logic [AW-1:0] a,
                                           input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    logic [DW-1:0] wd_m;
    logic [SW-1:0] ws_m;
    wd_m = wr ? wd : '0;
    ws_m = wr ? ws : '0;
    return {1'b0, wr, rd, ir, dr, a, wd_m, ws_m};
  endfunction

  function automatic logic [W-1:0] resp_rec(input logic mr, input logic ir, input logic dr,
                                            input logic [DW-1:0] d);
    return {1'b1, 1'b0, mr, ir, dr, {AW{1'b0}}, d, {SW{1'b0}}};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    checks = checks + 1;
    if (exp_q.size() == 0) begin
      errors = errors + 1;
      $display("FAIL %s: got unexpected event %0h expected none", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors = errors + 1;
        $display("FAIL %s: got %0h expected %0h", name, act, e);
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if ((bus.m_read || bus.m_write) && bus.m_req_ready)
      pop_cmp("mem_req", req_rec(bus.m_write, bus.m_read, bus.i_ready, bus.d_ready,
                                 bus.m_addr, bus.m_wdata, bus.m_wstrb));
    if ((bus.i_rvalid && bus.i_rready) || (bus.d_rvalid && bus.d_rready))
      pop_cmp("read_resp", resp_rec(bus.m_rready, bus.i_rvalid, bus.d_rvalid,
                                    bus.i_rvalid ? bus.i_rdata : bus.d_rdata));
    chk("exclusive", W'({bus.i_ready & bus.d_ready, bus.i_rvalid & bus.d_rvalid,
                         bus.m_read & bus.m_write}), '0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_addr = '0; bus.i_valid = 0; bus.i_rready = 0;
    bus.d_addr = '0; bus.d_read = 0; bus.d_write = 0; bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.d_rready = 0;
    bus.m_req_ready = 0; bus.m_rdata = '0; bus.m_rvalid = 0;
  endtask

  task automatic check_idle_zero(input string tag, input logic [31:0] exp_cnt);
    chk({tag, "_state"}, W'(dbg_state), W'(S_IDLE));
    chk({tag, "_ctl"}, W'({bus.i_ready, bus.i_rvalid, bus.d_ready, bus.d_rvalid,
                           bus.m_read, bus.m_write, bus.m_rready}), '0);
    chk({tag, "_data"}, W'({bus.i_rdata, bus.d_rdata}), '0);
    chk({tag, "_mem"}, W'({bus.m_addr, bus.m_wdata, bus.m_wstrb}), '0);
    chk({tag, "_cnt"}, W'(conflict_cnt), W'(exp_cnt));
  endtask

  task automatic fetch_solo(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_valid = 1; bus.i_addr = a; bus.i_rready = 1;
    bus.m_req_ready = 1; bus.m_rvalid = 1; bus.m_rdata = d;
    exp_q.push_back(req_rec(0, 1, 1, 0, a, '0, '0));
    exp_q.push_back(resp_rec(1, 1, 0, d));
    @(negedge clk);
    chk("fetch_c0_ready", W'(bus.i_ready), '0);
    tick();
    @(negedge clk);
    chk("fetch_c1_state", W'(dbg_state), W'(S_REQ));
    chk("fetch_c1_read", W'({bus.m_read, bus.i_ready}), W'(2'b11));
    tick();
    bus.i_valid = 0;
    @(negedge clk);
    chk("fetch_c2_state", W'(dbg_state), W'(S_RESP));
    chk("fetch_c2_rdata", W'({bus.i_rvalid, bus.i_rdata}), W'({1'b1, d}));
    tick();
    @(negedge clk);
    chk("fetch_c3_state", W'(dbg_state), W'(S_IDLE));
    clear_inputs();
  endtask

  task automatic issue_tie(input logic first_inst, input logic [AW-1:0] ia,
                           input logic [AW-1:0] da, input logic [DW-1:0] idat,
                           input logic [DW-1:0] ddat, input logic [31:0] exp_cnt);
    bus.i_valid = 1; bus.i_addr = ia; bus.i_rready = 1;
    bus.d_read = 1; bus.d_addr = da; bus.d_rready = 1;
    bus.m_req_ready = 1; bus.m_rvalid = 1;
    bus.m_rdata = first_inst ? idat : ddat;
    if (first_inst) begin
      exp_q.push_back(req_rec(0, 1, 1, 0, ia, '0, '0));
      exp_q.push_back(resp_rec(1, 1, 0, idat));
      exp_q.push_back(req_rec(0, 1, 0, 1, da, '0, '0));
      exp_q.push_back(resp_rec(1, 0, 1, ddat));
    end else begin
      exp_q.push_back(req_rec(0, 1, 0, 1, da, '0, '0));
      exp_q.push_back(resp_rec(1, 0, 1, ddat));
      exp_q.push_back(req_rec(0, 1, 1, 0, ia, '0, '0));
      exp_q.push_back(resp_rec(1, 1, 0, idat));
    end
    tick();
    @(negedge clk);
    chk("tie_win_state", W'(dbg_state), W'(S_REQ));
    chk("tie_win_ready", W'({bus.i_ready, bus.d_ready}), first_inst ? W'(2'b10) : W'(2'b01));
    chk("tie_cnt", W'(conflict_cnt), W'(exp_cnt));
    tick();
    if (first_inst) bus.i_valid = 0; else bus.d_read = 0;
    @(negedge clk);
    chk("tie_win_resp", W'(dbg_state), W'(S_RESP));
    tick();
    bus.m_rdata = first_inst ? ddat : idat;
    @(negedge clk);
    chk("tie_mid_idle", W'(dbg_state), W'(S_IDLE));
    tick();
    @(negedge clk);
    chk("tie_lose_ready", W'({bus.i_ready, bus.d_ready}), first_inst ? W'(2'b01) : W'(2'b10));
    tick();
    if (first_inst) bus.d_read = 0; else bus.i_valid = 0;
    @(negedge clk);
    chk("tie_lose_resp", W'(dbg_state), W'(S_RESP));
    tick();
    @(negedge clk);
    chk("tie_end_idle", W'(dbg_state), W'(S_IDLE));
    chk("tie_end_cnt", W'(conflict_cnt), W'(exp_cnt));
    clear_inputs();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clear_inputs();
    rst = 0;
    repeat (3) tick();
    rst = 1;
    @(negedge clk);
    check_idle_zero("reset", 32'd0);

    // fetch only, zero-wait memory
    tick();
    fetch_solo(32'h0000_0100, 32'h0000_0013);

    // store with three wait cycles on the request channel
    bus.d_write = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'hAABB_CCDD; bus.d_wstrb = 4'h4;
    exp_q.push_back(req_rec(1, 0, 0, 1, 32'h2004, 32'hAABB_CCDD, 4'h4));
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.m_req_ready = 1;
      @(negedge clk);
      chk("store_hold", W'({dbg_state, bus.m_write, bus.m_read, bus.m_addr, bus.m_wstrb, bus.d_ready}),
          W'({S_REQ, 1'b1, 1'b0, 32'h2004, 4'h4, (i == 3)}));
      tick();
    end
    clear_inputs();
    @(negedge clk);
    chk("store_no_resp", W'(dbg_state), W'(S_IDLE));
    chk("store_cnt", W'(conflict_cnt), '0);

    // ties: INST first after reset, then DATA wins once last_grant is INST
    tick();
    issue_tie(1'b1, 32'h200, 32'h300, 32'h1111_1111, 32'h2222_2222, 32'd1);
    tick();
    fetch_solo(32'h0000_0104, 32'h0000_0093);
    tick();
    issue_tie(1'b0, 32'h208, 32'h308, 32'h3333_3333, 32'h4444_4444, 32'd2);

    // load response backpressure
    tick();
    bus.d_read = 1; bus.d_addr = 32'h400; bus.m_req_ready = 1; bus.m_rvalid = 1;
    bus.m_rdata = 32'hCAFE_F00D; bus.i_rready = 1;
    exp_q.push_back(req_rec(0, 1, 0, 1, 32'h400, '0, '0));
    exp_q.push_back(resp_rec(1, 0, 1, 32'hCAFE_F00D));
    tick();
    tick();
    bus.d_read = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", W'({dbg_state, bus.m_rready, bus.d_rvalid, bus.i_rvalid}),
          W'({S_RESP, 1'b0, 1'b1, 1'b0}));
      tick();
    end
    bus.d_rready = 1;
    @(negedge clk);
    chk("bp_release", W'({bus.m_rready, bus.d_rvalid, bus.i_rvalid}), W'(3'b110));
    tick();
    clear_inputs();
    @(negedge clk);
    chk("bp_done", W'(dbg_state), W'(S_IDLE));

    // read and write together: the write wins, no response phase
    tick();
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h500;
    bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'hF; bus.m_req_ready = 1;
    exp_q.push_back(req_rec(1, 0, 0, 1, 32'h500, 32'h1234_5678, 4'hF));
    tick();
    @(negedge clk);
    chk("rw_req", W'({dbg_state, bus.m_write, bus.m_read}), W'({S_REQ, 1'b1, 1'b0}));
    tick();
    clear_inputs();
    @(negedge clk);
    chk("rw_no_resp", W'(dbg_state), W'(S_IDLE));

    // reset while a fetch waits in RESP
    tick();
    bus.i_valid = 1; bus.i_addr = 32'h600; bus.i_rready = 1; bus.m_req_ready = 1;
    bus.m_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(req_rec(0, 1, 1, 0, 32'h600, '0, '0));
    tick();
    tick();
    bus.i_valid = 0;
    @(negedge clk);
    chk("rst_mid_state", W'(dbg_state), W'(S_RESP));
    tick();
    rst = 0;
    tick();
    rst = 1;
    @(negedge clk);
    check_idle_zero("rst_mid", 32'd0);
    clear_inputs();
    tick();
    issue_tie(1'b1, 32'h700, 32'h800, 32'h5555_5555, 32'h6666_6666, 32'd1);

    repeat (3) tick();
    chk("queue_empty", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
